// File: rtl/rv32i_wb_arb_pkg.sv
// rv32i_wb_arb_pkg: shared types for the register-file write-port arbiter
package rv32i_wb_arb_pkg;
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;
  localparam logic [4:0] REG_X0 = 5'd0;
endpackage

// File: rtl/rv32i_sync_fifo.sv
// rv32i_sync_fifo: synchronous FIFO; a push into a full FIFO is taken only alongside a pop
module rv32i_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
  endfunction
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign dout    = mem[rp];
  assign do_pop  = pop & !empty;
  assign do_push = push & (!full | do_pop);
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= nxt(wp);
      if (do_pop) rp <= nxt(rp);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/rv32i_wb_port_arbiter.sv
// rv32i_wb_port_arbiter: shares the register-file write port between pipeline writeback and late IO loads
module rv32i_wb_port_arbiter
  import rv32i_wb_arb_pkg::*;
#(
  parameter int OUTST_DEPTH = 4,
  parameter int RSP_DEPTH   = 2,
  parameter int STARVE_LIM  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_en_in,
  input  logic [4:0]  wb_reg_in,
  input  logic [31:0] wb_data_in,
  input  logic        io_req_valid,
  input  logic [4:0]  io_req_reg,
  output logic        io_req_ready,
  input  logic        io_rsp_valid,
  input  logic [31:0] io_rsp_data,
  output logic        io_rsp_ready,
  output logic        rf_wr_en,
  output logic [4:0]  rf_wr_reg,
  output logic [31:0] rf_wr_data,
  output logic [31:0] pend_mask,
  output logic        stall_out,
  output logic        waw_err
);
  localparam int SW = $clog2(STARVE_LIM+1);
  logic tag_full, tag_empty, rsp_full, rsp_empty;
  logic issue, tag_pop, pipe, rsp_pop, nxt_en, starving, at_lim;
  logic [4:0] tag_head;
  wb_entry_t rsp_head, nxt_wr;
  logic [$clog2(OUTST_DEPTH+1)-1:0] tag_cnt;
  logic [$clog2(RSP_DEPTH+1)-1:0] rsp_cnt;
  logic [SW-1:0] starve, starve_inc;
  logic [31:0] pend_nxt;
  logic unused_cnt;
  assign unused_cnt   = ^{tag_cnt, rsp_cnt};
  assign io_req_ready = !reset & !tag_full & !pend_mask[io_req_reg];
  assign io_rsp_ready = !reset & !rsp_full;
  assign issue        = io_req_valid & io_req_ready;
  assign tag_pop      = io_rsp_valid & io_rsp_ready & !tag_empty;
  rv32i_sync_fifo #(.WIDTH(5), .DEPTH(OUTST_DEPTH)) u_tag (
    .clk(clk), .reset(reset), .push(issue), .pop(tag_pop), .din(io_req_reg),
    .dout(tag_head), .full(tag_full), .empty(tag_empty), .count(tag_cnt)
  );
  rv32i_sync_fifo #(.WIDTH($bits(wb_entry_t)), .DEPTH(RSP_DEPTH)) u_rsp (
    .clk(clk), .reset(reset), .push(tag_pop), .pop(rsp_pop),
    .din(wb_entry_t'{rd: tag_head, data: io_rsp_data}),
    .dout(rsp_head), .full(rsp_full), .empty(rsp_empty), .count(rsp_cnt)
  );
  always_comb begin
    pipe       = wb_en_in & (wb_reg_in != REG_X0);
    rsp_pop    = !pipe & !rsp_empty;
    nxt_en     = pipe | (rsp_pop & (rsp_head.rd != REG_X0));
    nxt_wr     = pipe ? wb_entry_t'{rd: wb_reg_in, data: wb_data_in} : rsp_head;
    starving   = pipe & !rsp_empty;
    starve_inc = starve + SW'(1);
    at_lim     = starving & (starve_inc == SW'(STARVE_LIM));
    // a new issue to a register being drained this cycle keeps its pending bit
    pend_nxt   = (pend_mask & ~(32'(rsp_pop) << rsp_head.rd))
               | (32'(issue & (io_req_reg != REG_X0)) << io_req_reg);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_wr_en   <= 1'b0;
      rf_wr_reg  <= '0;
      rf_wr_data <= '0;
      pend_mask  <= '0;
      stall_out  <= 1'b0;
      waw_err    <= 1'b0;
      starve     <= '0;
    end else begin
      rf_wr_en   <= nxt_en;
      rf_wr_reg  <= nxt_en ? nxt_wr.rd : '0;
      rf_wr_data <= nxt_en ? nxt_wr.data : '0;
      pend_mask  <= pend_nxt;
      waw_err    <= waw_err | (pipe & pend_mask[wb_reg_in]);
      stall_out  <= at_lim;
      starve     <= (rsp_pop | at_lim) ? '0 : starving ? starve_inc : starve;
    end
  end
endmodule

// File: tb/tb_rv32i_wb_port_arbiter.sv
// tb_rv32i_wb_port_arbiter: directed self-checking bench for the write-port arbiter
module tb_rv32i_wb_port_arbiter;
  logic        clk = 0, reset = 1;
  logic        wb_en_in = 0, io_req_valid = 0, io_rsp_valid = 0;
  logic [4:0]  wb_reg_in = 0, io_req_reg = 0;
  logic [31:0] wb_data_in = 0, io_rsp_data = 0;
  logic        io_req_ready, io_rsp_ready, rf_wr_en, stall_out, waw_err;
  logic [4:0]  rf_wr_reg;
  logic [31:0] rf_wr_data, pend_mask;
  int checks = 0, errors = 0;

  rv32i_wb_port_arbiter dut (
    .clk(clk), .reset(reset), .wb_en_in(wb_en_in), .wb_reg_in(wb_reg_in), .wb_data_in(wb_data_in),
    .io_req_valid(io_req_valid), .io_req_reg(io_req_reg), .io_req_ready(io_req_ready),
    .io_rsp_valid(io_rsp_valid), .io_rsp_data(io_rsp_data), .io_rsp_ready(io_rsp_ready),
    .rf_wr_en(rf_wr_en), .rf_wr_reg(rf_wr_reg), .rf_wr_data(rf_wr_data),
    .pend_mask(pend_mask), .stall_out(stall_out), .waw_err(waw_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] rd, input logic [31:0] d);
    chk({tag, "_en"}, 32'(rf_wr_en), 32'd1);
    chk({tag, "_reg"}, 32'(rf_wr_reg), 32'(rd));
    chk({tag, "_data"}, rf_wr_data, d);
  endtask

  initial begin
    tick();
    tick();
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_outs", {29'd0, rf_wr_en, stall_out, waw_err}, 32'd0);
      chk("idle_pend", pend_mask, 32'd0);
      chk("idle_ready", {30'd0, io_req_ready, io_rsp_ready}, 32'd3);
    end
    // single IO load to x5
    io_req_valid = 1; io_req_reg = 5;
    #1 chk("t2_req_ready", 32'(io_req_ready), 32'd1);
    tick();
    io_req_valid = 0;
    chk("t2_pend_set", pend_mask, 32'h20);
    io_rsp_valid = 1; io_rsp_data = 32'hDEADBEEF;
    tick();
    io_rsp_valid = 0;
    chk("t2_no_wr_yet", 32'(rf_wr_en), 32'd0);
    chk("t2_pend_held", pend_mask, 32'h20);
    tick();
    chk_wr("t2_wr", 5'd5, 32'hDEADBEEF);
    chk("t2_pend_clr", pend_mask, 32'd0);
    tick();
    chk("t2_idle", 32'(rf_wr_en), 32'd0);
    // starvation: x7 response waits behind continuous pipeline writes to x3
    io_req_valid = 1; io_req_reg = 7;
    tick();
    io_req_valid = 0;
    wb_en_in = 1; wb_reg_in = 3; wb_data_in = 32'h33;
    io_rsp_valid = 1; io_rsp_data = 32'h11;
    tick();
    io_rsp_valid = 0;
    chk_wr("t3_wb0", 5'd3, 32'h33);
    tick();
    chk("t3_stall_c1", 32'(stall_out), 32'd0);
    tick();
    chk("t3_stall_c2", 32'(stall_out), 32'd0);
    tick();
    chk("t3_stall_c3", 32'(stall_out), 32'd1);
    chk_wr("t3_wb3", 5'd3, 32'h33);
    chk("t3_pend7", pend_mask, 32'h80);
    tick();
    chk("t3_stall_once", 32'(stall_out), 32'd0);
    wb_en_in = 0;
    tick();
    chk_wr("t3_drain", 5'd7, 32'h11);
    chk("t3_pend_clr", pend_mask, 32'd0);
    chk("t3_waw", 32'(waw_err), 32'd0);
    // fill the tag FIFO
    for (int i = 1; i <= 4; i++) begin
      io_req_valid = 1; io_req_reg = 5'(i);
      #1 chk("t4_ready", 32'(io_req_ready), 32'd1);
      tick();
    end
    io_req_reg = 5;
    #1 chk("t4_full", 32'(io_req_ready), 32'd0);
    io_req_reg = 2;
    #1 chk("t4_dup", 32'(io_req_ready), 32'd0);
    tick();
    io_req_valid = 0;
    chk("t4_pend", pend_mask, 32'h1E);
    for (int i = 1; i <= 4; i++) begin
      io_rsp_valid = 1; io_rsp_data = 32'h100 + 32'(i);
      tick();
      if (i == 1) chk("t4_first", 32'(rf_wr_en), 32'd0);
      else chk_wr("t4_ret", 5'(i - 1), 32'h100 + 32'(i - 1));
    end
    io_rsp_valid = 0;
    tick();
    chk_wr("t4_ret4", 5'd4, 32'h104);
    chk("t4_pend_clr", pend_mask, 32'd0);
    // fill the response buffer while the pipeline is busy
    for (int i = 10; i <= 12; i++) begin
      io_req_valid = 1; io_req_reg = 5'(i);
      tick();
    end
    io_req_valid = 0;
    wb_en_in = 1; wb_reg_in = 3;
    io_rsp_valid = 1; io_rsp_data = 32'hA0;
    tick();
    io_rsp_data = 32'hA1;
    tick();
    io_rsp_data = 32'hA2;
    #1 chk("t5_rsp_full", 32'(io_rsp_ready), 32'd0);
    tick();
    chk("t5_held_pend", pend_mask, 32'h1C00);
    wb_en_in = 0;
    tick();
    chk_wr("t5_x10", 5'd10, 32'hA0);
    #1 chk("t5_rsp_ready", 32'(io_rsp_ready), 32'd1);
    tick();
    io_rsp_valid = 0;
    chk_wr("t5_x11", 5'd11, 32'hA1);
    tick();
    chk_wr("t5_x12", 5'd12, 32'hA2);
    tick();
    chk("t5_idle", 32'(rf_wr_en), 32'd0);
    chk("t5_pend", pend_mask, 32'd0);
    // write-after-write violation on x9
    io_req_valid = 1; io_req_reg = 9;
    tick();
    io_req_valid = 0;
    chk("t6_pend9", pend_mask, 32'h200);
    wb_en_in = 1; wb_reg_in = 9; wb_data_in = 32'h99;
    tick();
    wb_en_in = 0;
    chk("t6_waw", 32'(waw_err), 32'd1);
    chk_wr("t6_wb9", 5'd9, 32'h99);
    io_rsp_valid = 1; io_rsp_data = 32'h9A;
    tick();
    io_rsp_valid = 0;
    tick();
    chk_wr("t6_io9", 5'd9, 32'h9A);
    wb_en_in = 1; wb_reg_in = 0; wb_data_in = 32'hFF;
    tick();
    wb_en_in = 0;
    chk("t6_wb_x0", 32'(rf_wr_en), 32'd0);
    io_req_valid = 1; io_req_reg = 0;
    tick();
    io_req_valid = 0;
    chk("t6_pend_x0", pend_mask, 32'd0);
    io_rsp_valid = 1; io_rsp_data = 32'h55;
    tick();
    io_rsp_valid = 0;
    tick();
    chk("t6_io_x0", 32'(rf_wr_en), 32'd0);
    chk("t6_waw_sticky", 32'(waw_err), 32'd1);
    // reset mid-operation drops tag and in-flight response
    io_req_valid = 1; io_req_reg = 6;
    tick();
    io_req_valid = 0;
    chk("t7_pend6", pend_mask, 32'h40);
    reset = 1; io_rsp_valid = 1; io_rsp_data = 32'h66;
    tick();
    reset = 0; io_rsp_valid = 0;
    chk("t7_pend_rst", pend_mask, 32'd0);
    chk("t7_waw_rst", 32'(waw_err), 32'd0);
    tick();
    tick();
    chk("t7_no_wr", 32'(rf_wr_en), 32'd0);
    io_req_reg = 6;
    #1 chk("t7_ready6", 32'(io_req_ready), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
